// File: rtl/lsu_mmio_split.sv
// -----------------------------------------------------------------------------
// lsu_mmio_split
//
// Load/store unit for the pipelined RV32I core. It accepts one request at a
// time over a valid/ready handshake and returns a single-cycle response pulse.
// Targets are a word-organised, synchronous-read data RAM with byte enables,
// a 64-byte output MMIO block (LEDs, LCD, 7-seg digits) and a 32-byte input
// MMIO block (synchronised switches and buttons).
//
// Accesses that cross a word boundary are performed as two aligned beats when
// the build macro LSU_MISALIGN_SPLIT_EN is defined. Without it, such accesses
// complete with rsp_err_o set and have no side effects.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_valid_i/ready_o request handshake (ready only while idle)
//   req_we_i            1 = store, 0 = load
//   req_funct3_i        RV32I funct3 (size in [1:0], unsigned load in [2])
//   req_addr_i          byte address
//   req_wdata_i         store data, right-aligned
//   rsp_valid_o         one-cycle completion pulse
//   rsp_rdata_o         extended load data; 0 for stores and faults
//   rsp_err_o           access fault, qualified by rsp_valid_o
//   io_sw_i, io_btn_i   asynchronous board inputs
//   io_ledr_o, io_ledg_o, io_lcd_o, io_hex_o  board outputs
// -----------------------------------------------------------------------------
module lsu_mmio_split #(
    parameter int unsigned DMEM_AW   = 13,
    parameter logic [31:0] DMEM_BASE = 32'h0000_2000,
    parameter logic [31:0] OUT_BASE  = 32'h0000_7000,
    parameter logic [31:0] IN_BASE   = 32'h0000_7800,
    parameter int unsigned N_HEX     = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [2:0]           req_funct3_i,
    input  logic [31:0]          req_addr_i,
    input  logic [31:0]          req_wdata_i,
    output logic                 rsp_valid_o,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_err_o,
    input  logic [31:0]          io_sw_i,
    input  logic [7:0]           io_btn_i,
    output logic [31:0]          io_ledr_o,
    output logic [31:0]          io_ledg_o,
    output logic [31:0]          io_lcd_o,
    output logic [7*N_HEX-1:0]   io_hex_o
);

    localparam int unsigned WIDX_W = DMEM_AW - 2;
    localparam int unsigned DEPTH  = 1 << WIDX_W;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic                   we_q, we_d;
    logic [2:0]             funct3_q, funct3_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            beat0_q, beat0_d;
    logic [31:0]            io_rd_q, io_rd_d;
    logic [31:0]            ledr_q, ledr_d;
    logic [31:0]            ledg_q, ledg_d;
    logic [31:0]            lcd_q, lcd_d;
    logic [N_HEX-1:0][6:0]  hex_q, hex_d;
    logic [31:0]            sw_meta_q, sw_sync_q;
    logic [7:0]             btn_meta_q, btn_sync_q;

    logic [31:0]            mem [DEPTH];
    logic [31:0]            ram_rdata_q;

    // ---------------------------------------------------------------- decode
    logic        hit_dmem, hit_out, hit_in;
    logic [1:0]  off;
    logic        crossing, bad_f3, err;

    assign hit_dmem = (addr_q[31:DMEM_AW] == DMEM_BASE[31:DMEM_AW]);
    assign hit_out  = (addr_q[31:6] == OUT_BASE[31:6]);
    assign hit_in   = (addr_q[31:5] == IN_BASE[31:5]);
    assign off      = addr_q[1:0];

    always_comb begin
        crossing = ((funct3_q[1:0] == 2'b10) && (off != 2'd0)) ||
                   ((funct3_q[1:0] == 2'b01) && (off == 2'd3));
        bad_f3   = (funct3_q[1:0] == 2'b11) || (funct3_q == 3'b110);
        err      = !(hit_dmem || hit_out || hit_in) || bad_f3 ||
                   (we_q && funct3_q[2]) || (we_q && hit_in) ||
                   (crossing && !SPLIT_EN);
    end

    // ------------------------------------------------------ beat generation
    // The request is viewed as an 8-byte window starting at the aligned word;
    // the low half is beat 0 and the high half is beat 1.
    logic [3:0]        size_mask;
    logic [7:0]        be_wide;
    logic [63:0]       wdata_wide;
    logic              beat, acc_active, wr_en;
    logic [3:0]        be_beat;
    logic [31:0]       wd_beat;
    logic [WIDX_W-1:0] dmem_idx;
    logic [3:0]        out_idx;
    logic [2:0]        in_idx;

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        be_wide    = {4'b0000, size_mask} << off;
        wdata_wide = {32'b0, wdata_q} << {off, 3'b000};
        beat       = (state_q == S_ACC1);
        acc_active = (state_q == S_ACC0) || (state_q == S_ACC1);
        be_beat    = beat ? be_wide[7:4] : be_wide[3:0];
        wd_beat    = beat ? wdata_wide[63:32] : wdata_wide[31:0];
        wr_en      = acc_active && we_q && !err;
        // Second-beat indices wrap within their own region.
        dmem_idx   = addr_q[DMEM_AW-1:2] + WIDX_W'(beat);
        out_idx    = addr_q[5:2] + 4'(beat);
        in_idx     = addr_q[4:2] + 3'(beat);
    end

    // ------------------------------------------------------------- data RAM
    // NOTE: the RAM array is deliberately not reset; only control state is,
    // which keeps it mappable onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en && hit_dmem) begin
            for (int b = 0; b < 4; b++) begin
                if (be_beat[b]) mem[dmem_idx][8*b +: 8] <= wd_beat[8*b +: 8];
            end
        end
        ram_rdata_q <= mem[dmem_idx];
    end

    // ------------------------------------------------------- MMIO read words
    logic [63:0] hex_bytes;
    logic [31:0] out_word, in_word, rd_word;

    always_comb begin
        hex_bytes = '0;
        for (int i = 0; i < N_HEX; i++) hex_bytes[8*i +: 7] = hex_q[i];
        case (out_idx)
            4'd0:    out_word = ledr_q;
            4'd4:    out_word = ledg_q;
            4'd8:    out_word = hex_bytes[31:0];
            4'd9:    out_word = hex_bytes[63:32];
            4'd12:   out_word = lcd_q;
            default: out_word = '0;
        endcase
        case (in_idx)
            3'd0:    in_word = sw_sync_q;
            3'd4:    in_word = {24'b0, btn_sync_q};
            default: in_word = '0;
        endcase
        // MMIO reads are registered like the RAM so both sources share timing.
        rd_word = hit_dmem ? ram_rdata_q : io_rd_q;
    end

    // ------------------------------------------------- datapath next values
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        ledr_d  = ledr_q;
        ledg_d  = ledg_q;
        lcd_d   = lcd_q;
        hex_d   = hex_q;
        io_rd_d = acc_active ? (hit_out ? out_word : in_word) : io_rd_q;
        // Beat-0 read data is presented during ACC1 and must be held for RESP.
        beat0_d = (state_q == S_ACC1) ? rd_word : beat0_q;

        if (wr_en && hit_out) begin
            for (int b = 0; b < 4; b++) begin
                if (be_beat[b]) begin
                    if (out_idx == 4'd0)  ledr_d[8*b +: 8] = wd_beat[8*b +: 8];
                    if (out_idx == 4'd4)  ledg_d[8*b +: 8] = wd_beat[8*b +: 8];
                    if (out_idx == 4'd12) lcd_d[8*b +: 8]  = wd_beat[8*b +: 8];
                end
            end
            for (int i = 0; i < N_HEX; i++) begin
                if ((out_idx == 4'(8 + i / 4)) && be_beat[i % 4])
                    hex_d[i] = wd_beat[8*(i % 4) +: 7];
            end
        end
    end

    // ---------------------------------------------------- FSM and response
    logic [31:0] load_lo, load_hi, load_word, load_ext;

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_ready_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d  = S_ACC0;
                    we_d     = req_we_i;
                    funct3_d = req_funct3_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                end
            end
            // err already covers crossings in the non-split build.
            S_ACC0:  state_d = (crossing && !err) ? S_ACC1 : S_RESP;
            S_ACC1:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Little-endian merge of the two beats, then shift the target bytes down.
        load_lo   = crossing ? beat0_q : rd_word;
        load_hi   = crossing ? rd_word : 32'b0;
        load_word = 32'({load_hi, load_lo} >> {off, 3'b000});
        case (funct3_q[1:0])
            2'b00:   load_ext = {{24{load_word[7] & ~funct3_q[2]}}, load_word[7:0]};
            2'b01:   load_ext = {{16{load_word[15] & ~funct3_q[2]}}, load_word[15:0]};
            default: load_ext = load_word;
        endcase

        rsp_valid_o = (state_q == S_RESP);
        rsp_err_o   = rsp_valid_o && err;
        rsp_rdata_o = (rsp_valid_o && !we_q && !err) ? load_ext : 32'b0;
    end

    // ------------------------------------------------------------ registers
    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            beat0_q    <= '0;
            io_rd_q    <= '0;
            ledr_q     <= '0;
            ledg_q     <= '0;
            lcd_q      <= '0;
            hex_q      <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            beat0_q    <= beat0_d;
            io_rd_q    <= io_rd_d;
            ledr_q     <= ledr_d;
            ledg_q     <= ledg_d;
            lcd_q      <= lcd_d;
            hex_q      <= hex_d;
            sw_meta_q  <= io_sw_i;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= io_btn_i;
            btn_sync_q <= btn_meta_q;
        end
    end

    assign io_ledr_o = ledr_q;
    assign io_ledg_o = ledg_q;
    assign io_lcd_o  = lcd_q;
    assign io_hex_o  = hex_q;

endmodule

// File: tb/tb_lsu_mmio_split.sv
// -----------------------------------------------------------------------------
// tb_lsu_mmio_split
//
// Directed bench for lsu_mmio_split with default parameters. Expected values
// are hand-computed; crossing-access expectations follow LSU_MISALIGN_SPLIT_EN.
// -----------------------------------------------------------------------------
module tb_lsu_mmio_split;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [2:0]  req_funct3_i = '0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] io_sw_i = '0;
    logic [7:0]  io_btn_i = '0;
    logic [31:0] io_ledr_o;
    logic [31:0] io_ledg_o;
    logic [31:0] io_lcd_o;
    logic [55:0] io_hex_o;

    int n_cmp = 0;
    int n_bad = 0;

    lsu_mmio_split dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .io_sw_i      (io_sw_i),
        .io_btn_i     (io_btn_i),
        .io_ledr_o    (io_ledr_o),
        .io_ledg_o    (io_ledg_o),
        .io_lcd_o     (io_lcd_o),
        .io_hex_o     (io_hex_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request from just after a rising edge; accept happens at the
    // next edge (cycle N). Latency counts the cycle in which rsp_valid_o is seen.
    task automatic run(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int lat;
        logic [31:0] rd;
        logic er;
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wd;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        lat = 1;
        while (rsp_valid_o !== 1'b1 && lat < 20) begin
            @(posedge clk_i); #1;
            lat++;
        end
        rd = rsp_rdata_o;
        er = rsp_err_o;
        check({tag, ".lat"},   64'(lat), 64'(exp_lat));
        check({tag, ".err"},   64'(er),  64'(exp_err));
        check({tag, ".rdata"}, 64'(rd),  64'(exp_rd));
        @(posedge clk_i); #1;
    endtask

    initial begin
        // ---- reset state
        #2;
        check("rst.rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst.rsp_err",   64'(rsp_err_o),   64'd0);
        check("rst.rsp_rdata", 64'(rsp_rdata_o), 64'd0);
        check("rst.ledr",      64'(io_ledr_o),   64'd0);
        check("rst.hex",       64'(io_hex_o),    64'd0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        check("idle.ready", 64'(req_ready_o), 64'd1);

        // ---- aligned word and byte accesses
        run("sw_2000",  1'b1, 3'b010, 32'h2000, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
        run("lw_2000",  1'b0, 3'b010, 32'h2000, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
        run("sb_2001",  1'b1, 3'b000, 32'h2001, 32'h0000_0080, 32'h0, 1'b0, 2);
        run("lb_2001",  1'b0, 3'b000, 32'h2001, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
        run("lbu_2001", 1'b0, 3'b100, 32'h2001, 32'h0, 32'h0000_0080, 1'b0, 2);
        run("lw_2000b", 1'b0, 3'b010, 32'h2000, 32'h0, 32'hDEAD_80EF, 1'b0, 2);

        // ---- word-crossing accesses
        run("sw_2004", 1'b1, 3'b010, 32'h2004, 32'h0, 32'h0, 1'b0, 2);
        run("sw_2008", 1'b1, 3'b010, 32'h2008, 32'h0, 32'h0, 1'b0, 2);
        run("sw_2006", 1'b1, 3'b010, 32'h2006, 32'h1122_3344, 32'h0, !SPLIT, SPLIT ? 3 : 2);
        run("lw_2006", 1'b0, 3'b010, 32'h2006, 32'h0, SPLIT ? 32'h1122_3344 : 32'h0, !SPLIT, SPLIT ? 3 : 2);
        run("lw_2004", 1'b0, 3'b010, 32'h2004, 32'h0, SPLIT ? 32'h3344_0000 : 32'h0, 1'b0, 2);
        run("lw_2008", 1'b0, 3'b010, 32'h2008, 32'h0, SPLIT ? 32'h0000_1122 : 32'h0, 1'b0, 2);
        run("lhu_2006", 1'b0, 3'b101, 32'h2006, 32'h0, SPLIT ? 32'h0000_3344 : 32'h0, 1'b0, 2);
        run("lh_2007", 1'b0, 3'b001, 32'h2007, 32'h0, SPLIT ? 32'h0000_2233 : 32'h0, !SPLIT, SPLIT ? 3 : 2);
        // Crossing the top of the RAM wraps to word 0 (byte 0x2000 = 0xEF).
        run("sw_3ffc", 1'b1, 3'b010, 32'h3FFC, 32'hAABB_CCDD, 32'h0, 1'b0, 2);
        run("lh_3fff", 1'b0, 3'b001, 32'h3FFF, 32'h0, SPLIT ? 32'hFFFF_EFAA : 32'h0, !SPLIT, SPLIT ? 3 : 2);

        // ---- output MMIO
        run("sw_hex0", 1'b1, 3'b010, 32'h7020, 32'h0000_007F, 32'h0, 1'b0, 2);
        check("hex_after_sw", 64'(io_hex_o), 64'h7F);
        run("sw_ledr", 1'b1, 3'b010, 32'h7000, 32'hA5A5_A5A5, 32'h0, 1'b0, 2);
        check("ledr", 64'(io_ledr_o), 64'hA5A5_A5A5);
        run("sb_hex1", 1'b1, 3'b000, 32'h7021, 32'h0000_00FF, 32'h0, 1'b0, 2);
        check("hex_after_sb", 64'(io_hex_o), 64'h3FFF);
        run("lw_hex",  1'b0, 3'b010, 32'h7020, 32'h0, 32'h0000_7F7F, 1'b0, 2);
        run("sh_ledg", 1'b1, 3'b001, 32'h7012, 32'h0000_BEEF, 32'h0, 1'b0, 2);
        check("ledg", 64'(io_ledg_o), 64'hBEEF_0000);
        run("sw_lcd",  1'b1, 3'b010, 32'h7030, 32'h1357_9BDF, 32'h0, 1'b0, 2);
        check("lcd", 64'(io_lcd_o), 64'h1357_9BDF);
        run("sw_unimp", 1'b1, 3'b010, 32'h7004, 32'hFFFF_FFFF, 32'h0, 1'b0, 2);
        run("lw_unimp", 1'b0, 3'b010, 32'h7004, 32'h0, 32'h0, 1'b0, 2);

        // ---- input MMIO
        io_sw_i  = 32'h1234_5678;
        io_btn_i = 8'h5A;
        repeat (3) begin @(posedge clk_i); #1; end
        run("lw_sw",   1'b0, 3'b010, 32'h7800, 32'h0, 32'h1234_5678, 1'b0, 2);
        run("lbu_sw1", 1'b0, 3'b100, 32'h7801, 32'h0, 32'h0000_0056, 1'b0, 2);
        run("lw_btn",  1'b0, 3'b010, 32'h7810, 32'h0, 32'h0000_005A, 1'b0, 2);

        // ---- faults
        run("sw_in",    1'b1, 3'b010, 32'h7800, 32'hFFFF_FFFF, 32'h0, 1'b1, 2);
        run("lw_9000",  1'b0, 3'b010, 32'h9000, 32'h0, 32'h0, 1'b1, 2);
        run("ld_f3_011", 1'b0, 3'b011, 32'h2000, 32'h0, 32'h0, 1'b1, 2);
        run("st_f3_100", 1'b1, 3'b100, 32'h2000, 32'h0, 32'h0, 1'b1, 2);
        run("lw_2000c", 1'b0, 3'b010, 32'h2000, 32'h0, 32'hDEAD_80EF, 1'b0, 2);

        // ---- reset in the middle of a store
        run("sw_2104", 1'b1, 3'b010, 32'h2104, 32'h5555_AAAA, 32'h0, 1'b0, 2);
        run("sw_2108", 1'b1, 3'b010, 32'h2108, 32'h0, 32'h0, 1'b0, 2);
        req_valid_i  = 1'b1;
        req_we_i     = 1'b1;
        req_funct3_i = 3'b010;
        req_addr_i   = SPLIT ? 32'h2106 : 32'h2104;
        req_wdata_i  = 32'hCAFE_F00D;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        // Now in ACC0. In the split build advance into ACC1 so beat 0 lands.
        if (SPLIT) begin
            @(posedge clk_i); #1;
        end
        rst_i = 1'b1;
        #1;
        check("midrst.rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("midrst.rsp_rdata", 64'(rsp_rdata_o), 64'd0);
        check("midrst.ledr",      64'(io_ledr_o),   64'd0);
        check("midrst.hex",       64'(io_hex_o),    64'd0);
        check("midrst.lcd",       64'(io_lcd_o),    64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        #1;
        check("midrst.ready", 64'(req_ready_o), 64'd1);
        @(posedge clk_i); #1;
        // Split: bytes 0x2106/0x2107 took 0x0D/0xF0; word 0x2108 untouched.
        // No split: the aborted store left 0x2104 unchanged.
        run("lw_2104", 1'b0, 3'b010, 32'h2104, 32'h0, SPLIT ? 32'hF00D_AAAA : 32'h5555_AAAA, 1'b0, 2);
        run("lw_2108", 1'b0, 3'b010, 32'h2108, 32'h0, 32'h0, 1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
